// File: rtl/gate_pattern_pkg.sv
// Shared types and the gate evaluation helper for the gate pattern generator.
package gate_pattern_pkg;

    typedef enum logic [1:0] {
        GATE_AND,
        GATE_OR,
        GATE_XOR,
        GATE_NAND
    } gate_mode_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_STOP
    } gp_state_t;

    // Evaluate the selected 2-input gate
    function automatic logic gate_eval(gate_mode_t mode, logic a, logic b);
        logic r;
        unique case (mode)
            GATE_AND:  r = a & b;
            GATE_OR:   r = a | b;
            GATE_XOR:  r = a ^ b;
            GATE_NAND: r = ~(a & b);
            default:   r = 1'b0;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/gp_prescaler.sv
// Step prescaler: counts 0..DIV-1 while enabled and flags the last count as a tick.
module gp_prescaler #(
    parameter int unsigned DIV   = 24_000_000,
    parameter int unsigned DIV_W = $clog2(DIV)
) (
    input  logic clk,
    input  logic reset,
    input  logic en,
    input  logic clr,
    output logic tick
);

    localparam logic [DIV_W-1:0] CntLast = DIV_W'(DIV - 1);

    logic [DIV_W-1:0] cnt_q, cnt_d;

    // Tick is high for the whole cycle the counter sits at its last value
    assign tick = en && (cnt_q == CntLast);

    // Next count: clear has priority, wrap at the last value
    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (en) begin
            cnt_d = tick ? '0 : cnt_q + DIV_W'(1);
        end
    end

    // Counter register with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/gate_pattern_gen.sv
// Multi-channel logic-gate LED test generator. Each channel walks the 2-input
// truth table, offset by its channel index, and shows the selected gate on y.
// Optional build macro TRISTATE_Y_EN adds y_oe to release the y pins.
module gate_pattern_gen
    import gate_pattern_pkg::*;
#(
    parameter int unsigned N_CH  = 1,
    parameter int unsigned DIV   = 24_000_000,
    parameter int unsigned DIV_W = $clog2(DIV)
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            run,
    input  logic [1:0]      mode,
`ifdef TRISTATE_Y_EN
    input  logic            y_oe,
`endif
    output logic [N_CH-1:0] a,
    output logic [N_CH-1:0] b,
    output logic [N_CH-1:0] y,
    output logic            tick,
    output logic            busy
);

    gp_state_t       state_q, state_d;
    logic [1:0]      phase_q, phase_d;
    gate_mode_t      mode_q, mode_d;
    logic [N_CH-1:0] a_q, a_d;
    logic [N_CH-1:0] b_q, b_d;
    logic [N_CH-1:0] y_q, y_d;
    logic            tick_w;
    logic            pre_en;
    logic            pre_clr;
    logic            out_en;

    // Counter is held at zero in IDLE so RUN entry always starts a fresh step
    assign pre_en  = (state_q != ST_IDLE);
    assign pre_clr = (state_q == ST_IDLE);

    gp_prescaler #(
        .DIV   (DIV),
        .DIV_W (DIV_W)
    ) u_prescaler (
        .clk   (clk),
        .reset (reset),
        .en    (pre_en),
        .clr   (pre_clr),
        .tick  (tick_w)
    );

    // FSM next state plus phase/mode updates on entry and step boundaries
    always_comb begin
        state_d = state_q;
        phase_d = phase_q;
        mode_d  = mode_q;
        unique case (state_q)
            ST_IDLE: begin
                if (run) begin
                    state_d = ST_RUN;
                    phase_d = 2'd0;
                    mode_d  = gate_mode_t'(mode);
                end
            end
            ST_RUN: begin
                // Only run at the tick decides whether the step is the last one
                if (!run) begin
                    state_d = tick_w ? ST_IDLE : ST_STOP;
                end
            end
            ST_STOP: begin
                if (run) begin
                    state_d = ST_RUN;
                end else if (tick_w) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        if (tick_w && (state_d != ST_IDLE)) begin
            phase_d = phase_q + 2'd1;
            mode_d  = gate_mode_t'(mode);
        end
    end

    // Outputs are computed from next-state values so they land with the step
    assign out_en = (state_d != ST_IDLE);

    // Per-channel row: channel k runs k rows ahead of channel 0
    for (genvar k = 0; k < N_CH; k++) begin : g_ch
        logic [1:0] ph;
        assign ph     = phase_d + 2'(k);
        assign a_d[k] = out_en & ph[0];
        assign b_d[k] = out_en & ph[1];
        assign y_d[k] = out_en & gate_eval(mode_d, ph[0], ph[1]);
    end

    // State and registered outputs; reset wins over everything
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            phase_q <= 2'd0;
            mode_q  <= GATE_AND;
            a_q     <= '0;
            b_q     <= '0;
            y_q     <= '0;
        end else begin
            state_q <= state_d;
            phase_q <= phase_d;
            mode_q  <= mode_d;
            a_q     <= a_d;
            b_q     <= b_d;
            y_q     <= y_d;
        end
    end

    assign a    = a_q;
    assign b    = b_q;
    assign tick = tick_w;
    assign busy = (state_q != ST_IDLE);

`ifdef TRISTATE_Y_EN
    // y pins are released while y_oe is low; y_q keeps tracking underneath
    assign y = y_oe ? y_q : {N_CH{1'bz}};
`else
    assign y = y_q;
`endif

endmodule
